// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared widths and FSM encoding for the MEM-stage SRAM controller.
// Imported by mem_stage_sram_ctrl and sram_phase_counter.
package mem_stage_sram_ctrl_pkg;

    localparam int LEN_SRAM_DATA    = 16;
    localparam int LEN_SRAM_ADDRESS = 18;
    localparam int LEN_WAIT_CNT     = 4;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_LO   = 2'd1,
        MEM_ST_HI   = 2'd2,
        MEM_ST_DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_counter.sv
// Loadable down-counter with terminal-count flag, shared by the
// low and high half-word phases of an SRAM access.
module sram_phase_counter
    import mem_stage_sram_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    dec,
    input  logic [LEN_WAIT_CNT-1:0] load_val,
    output logic                    tc
);

    logic [LEN_WAIT_CNT-1:0] cnt;

    // Reload at phase start, otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit load/store over a 16-bit SRAM in two half-word phases.
// Optional macro SRAM_BOUNDS_CHECK_EN adds the err port and range check.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int MEM_BASE    = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_ADDR_W = LEN_SRAM_ADDRESS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read_in,
    input  logic                     mem_write_in,
    input  logic [31:0]              alu_result_in,
    input  logic [31:0]              store_data_in,
    output logic [31:0]              mem_result,
    output logic                     ready,
    output logic [SRAM_ADDR_W-1:0]   sram_addr,
    output logic [LEN_SRAM_DATA-1:0] sram_wdata,
    input  logic [LEN_SRAM_DATA-1:0] sram_rdata,
    output logic                     sram_dq_oe,
    output logic                     sram_we_n
`ifdef SRAM_BOUNDS_CHECK_EN
    ,
    output logic                     err
`endif
);

    localparam int WORD_W = SRAM_ADDR_W - 1;
    localparam logic [LEN_WAIT_CNT-1:0] RELOAD =
        LEN_WAIT_CNT'(WAIT_CYCLES - 1);

    mem_state_t state;
    mem_state_t state_nxt;

    logic                     req;
    logic [31:0]              off;
    logic [WORD_W-1:0]        word_in;
    logic [WORD_W-1:0]        word_q;
    logic [15:0]              data_hi_q;
    logic                     wr_q;
    logic                     accept;
    logic                     oob;
    logic                     cnt_load;
    logic                     cnt_dec;
    logic                     cnt_tc;
    logic [SRAM_ADDR_W-1:0]   addr_nxt;
    logic [LEN_SRAM_DATA-1:0] wdata_nxt;
    logic                     oe_nxt;
    logic                     we_n_nxt;
    logic                     unused_off;

    assign req     = mem_read_in | mem_write_in;
    assign off     = alu_result_in - 32'(MEM_BASE);
    assign word_in = off[SRAM_ADDR_W:2];

`ifdef SRAM_BOUNDS_CHECK_EN
    assign oob = (alu_result_in < 32'(MEM_BASE)) ||
                 (off[31:SRAM_ADDR_W+1] != '0);
    assign unused_off = ^off[1:0];
`else
    assign oob = 1'b0;
    assign unused_off = ^{off[31:SRAM_ADDR_W+1], off[1:0]};
`endif

    sram_phase_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (RELOAD),
        .tc       (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MEM_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall, counter control and next SRAM bus values.
    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        accept    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        addr_nxt  = sram_addr;
        wdata_nxt = sram_wdata;
        oe_nxt    = sram_dq_oe;
        we_n_nxt  = sram_we_n;
        unique case (state)
            MEM_ST_IDLE: begin
                if (req) begin
                    ready    = 1'b0;
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    if (oob) begin
                        state_nxt = MEM_ST_DONE;
                    end else begin
                        state_nxt = MEM_ST_LO;
                        addr_nxt  = {word_in, 1'b0};
                        wdata_nxt = store_data_in[15:0];
                        oe_nxt    = mem_write_in;
                        we_n_nxt  = ~mem_write_in;
                    end
                end
            end
            MEM_ST_LO: begin
                ready = 1'b0;
                if (cnt_tc) begin
                    cnt_load  = 1'b1;
                    state_nxt = MEM_ST_HI;
                    addr_nxt  = {word_q, 1'b1};
                    wdata_nxt = data_hi_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MEM_ST_HI: begin
                ready = 1'b0;
                if (cnt_tc) begin
                    state_nxt = MEM_ST_DONE;
                    oe_nxt    = 1'b0;
                    we_n_nxt  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MEM_ST_DONE: begin
                state_nxt = MEM_ST_IDLE;
            end
            default: begin
                state_nxt = MEM_ST_IDLE;
            end
        endcase
    end

    // Registered SRAM bus; reset forces the write strobe high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
        end else begin
            sram_addr  <= addr_nxt;
            sram_wdata <= wdata_nxt;
            sram_dq_oe <= oe_nxt;
            sram_we_n  <= we_n_nxt;
        end
    end

    // Capture the request so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q    <= '0;
            data_hi_q <= '0;
            wr_q      <= 1'b0;
        end else if (accept) begin
            word_q <= word_in;
            wr_q   <= mem_write_in;
            if (mem_write_in) begin
                data_hi_q <= store_data_in[31:16];
            end
        end
    end

    // Load result: each half captured in the last cycle of its phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_result <= '0;
        end else begin
            unique case (1'b1)
                accept && oob && !mem_write_in:
                    mem_result <= '0;
                state == MEM_ST_LO && cnt_tc && !wr_q:
                    mem_result[15:0] <= sram_rdata;
                state == MEM_ST_HI && cnt_tc && !wr_q:
                    mem_result[31:16] <= sram_rdata;
                default: ;
            endcase
        end
    end

`ifdef SRAM_BOUNDS_CHECK_EN
    // Error flag is high only during the DONE of a rejected access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= accept & oob;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM.
// Covers SRAM_BOUNDS_CHECK_EN builds as well as the default build.
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [31:0] mem_result;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_dq_oe, sram_we_n;

    logic        rd3, wr3;
    logic [31:0] addr3, wdata3;
    logic [31:0] result3;
    logic        ready3;
    logic [17:0] sram_addr3;
    logic [15:0] sram_wdata3, sram_rdata3;
    logic        sram_dq_oe3, sram_we_n3;

`ifdef SRAM_BOUNDS_CHECK_EN
    logic        err, err3;
`endif

    logic [15:0] mem  [64];
    logic [15:0] mem3 [64];
    int          wr_strobes = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(
        .MEM_BASE(1024), .WAIT_CYCLES(1), .SRAM_ADDR_W(18)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_in   (rd),
        .mem_write_in  (wr),
        .alu_result_in (addr),
        .store_data_in (wdata),
        .mem_result    (mem_result),
        .ready         (ready),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .sram_dq_oe    (sram_dq_oe),
        .sram_we_n     (sram_we_n)
`ifdef SRAM_BOUNDS_CHECK_EN
        ,
        .err           (err)
`endif
    );

    mem_stage_sram_ctrl #(
        .MEM_BASE(1024), .WAIT_CYCLES(3), .SRAM_ADDR_W(18)
    ) u_dut3 (
        .clk           (clk),
        .rst           (rst),
        .mem_read_in   (rd3),
        .mem_write_in  (wr3),
        .alu_result_in (addr3),
        .store_data_in (wdata3),
        .mem_result    (result3),
        .ready         (ready3),
        .sram_addr     (sram_addr3),
        .sram_wdata    (sram_wdata3),
        .sram_rdata    (sram_rdata3),
        .sram_dq_oe    (sram_dq_oe3),
        .sram_we_n     (sram_we_n3)
`ifdef SRAM_BOUNDS_CHECK_EN
        ,
        .err           (err3)
`endif
    );

    assign sram_rdata  = mem[sram_addr[5:0]];
    assign sram_rdata3 = mem3[sram_addr3[5:0]];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_wdata;
            wr_strobes <= wr_strobes + 1;
        end
        if (!sram_we_n3) begin
            mem3[sram_addr3[5:0]] <= sram_wdata3;
        end
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        logic [31:0] result;
        int          strobes;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int s0;
        @(negedge clk);
        rd    = v.rd;
        wr    = v.wr;
        addr  = v.addr;
        wdata = v.data;
        s0    = wr_strobes;
        #1;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        rd = 1'b0;
        wr = 1'b0;
        chk({v.name, " stall"}, 32'(n), 32'(v.stall));
        chk({v.name, " result"}, mem_result, v.result);
        chk({v.name, " strobes"}, 32'(wr_strobes - s0),
            32'(v.strobes));
        chk({v.name, " we_n idle"}, 32'(sram_we_n), 32'd1);
        chk({v.name, " oe idle"}, 32'(sram_dq_oe), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]  = 16'h0;
            mem3[i] = 16'h0;
        end
        mem[2]  = 16'h5678;
        mem[3]  = 16'h1234;
        mem3[2] = 16'hCAFE;
        mem3[3] = 16'hF00D;

        vecs[0] = '{"ld1028", 1, 0, 1028, 0, 3, 32'h12345678, 0};
        vecs[1] = '{"ld1024", 1, 0, 1024, 0, 3, 32'hDEADBEEF, 0};
        vecs[2] = '{"rdwr1032", 1, 1, 1032, 32'hA5A5A5A5, 3,
                    32'hDEADBEEF, 2};
        vecs[3] = '{"ld1034", 1, 0, 1034, 0, 3, 32'hA5A5A5A5, 0};
        vecs[4] = '{"st1100", 0, 1, 1100, 32'h0BADF00D, 3,
                    32'hA5A5A5A5, 2};
        vecs[5] = '{"ld1100", 1, 0, 1100, 0, 3, 32'h0BADF00D, 0};
`ifdef SRAM_BOUNDS_CHECK_EN
        vecs[6] = '{"ld_oob_hi", 1, 0, 525312, 0, 1, 32'h0, 0};
`else
        vecs[6] = '{"ld_wrap", 1, 0, 525312, 0, 3, 32'hDEADBEEF, 0};
`endif
        vecs[7] = '{"st1028", 0, 1, 1028, 32'hCAFEBABE, 3,
                    vecs[6].result, 2};
        vecs[8] = '{"ld1028b", 1, 0, 1028, 0, 3, 32'hCAFEBABE, 0};

        rst = 1'b0;
        rd = 0; wr = 0; addr = 0; wdata = 0;
        rd3 = 0; wr3 = 0; addr3 = 0; wdata3 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst result", mem_result, 32'h0);
        chk("rst we_n", 32'(sram_we_n), 32'd1);
        chk("rst oe", 32'(sram_dq_oe), 32'd0);
        chk("rst addr", 32'(sram_addr), 32'h0);
        chk("rst wdata", 32'(sram_wdata), 32'h0);

        // Store with inputs changed mid-access.
        @(negedge clk);
        wr = 1; addr = 1024; wdata = 32'hDEADBEEF;
        #1;
        chk("st c0 ready", 32'(ready), 32'd0);
        chk("st c0 we_n", 32'(sram_we_n), 32'd1);
        @(negedge clk);
        wr = 0; addr = 2000; wdata = 32'h0;
        #1;
        chk("st lo addr", 32'(sram_addr), 32'd0);
        chk("st lo wdata", 32'(sram_wdata), 32'hBEEF);
        chk("st lo we_n", 32'(sram_we_n), 32'd0);
        chk("st lo oe", 32'(sram_dq_oe), 32'd1);
        chk("st lo ready", 32'(ready), 32'd0);
        @(negedge clk);
        #1;
        chk("st hi addr", 32'(sram_addr), 32'd1);
        chk("st hi wdata", 32'(sram_wdata), 32'hDEAD);
        chk("st hi we_n", 32'(sram_we_n), 32'd0);
        chk("st hi ready", 32'(ready), 32'd0);
        @(negedge clk);
        #1;
        chk("st done ready", 32'(ready), 32'd1);
        chk("st done we_n", 32'(sram_we_n), 32'd1);
        chk("st done oe", 32'(sram_dq_oe), 32'd0);
        chk("st done result", mem_result, 32'h0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end
        chk("mem0", 32'(mem[0]), 32'hBEEF);
        chk("mem1", 32'(mem[1]), 32'hDEAD);
        chk("mem38", 32'(mem[38]), 32'hF00D);
        chk("mem39", 32'(mem[39]), 32'h0BAD);

        // Back-to-back: request held through DONE is re-sampled.
        begin
            int n;
            @(negedge clk);
            rd = 1; addr = 1024;
            #1;
            n = 0;
            while (ready !== 1'b1 && n < 50) begin
                @(negedge clk); #1; n++;
            end
            chk("b2b first stall", 32'(n), 32'd3);
            @(negedge clk);
            #1;
            chk("b2b idle accept", 32'(ready), 32'd0);
            n = 0;
            while (ready !== 1'b1 && n < 50) begin
                @(negedge clk); #1; n++;
            end
            rd = 0;
            chk("b2b second stall", 32'(n), 32'd3);
            chk("b2b result", mem_result, 32'hDEADBEEF);
        end

`ifdef SRAM_BOUNDS_CHECK_EN
        begin
            int s0;
            @(negedge clk);
            rd = 1; addr = 512;
            s0 = wr_strobes;
            #1;
            chk("oob c0 ready", 32'(ready), 32'd0);
            @(negedge clk);
            #1;
            rd = 0;
            chk("oob ready", 32'(ready), 32'd1);
            chk("oob err", 32'(err), 32'd1);
            chk("oob result", mem_result, 32'h0);
            chk("oob we_n", 32'(sram_we_n), 32'd1);
            chk("oob strobes", 32'(wr_strobes - s0), 32'd0);
            @(negedge clk);
            #1;
            chk("oob err clr", 32'(err), 32'd0);
        end
`endif

        // Slow SRAM: each half held three cycles.
        @(negedge clk);
        rd3 = 1; addr3 = 1028;
        #1;
        chk("w3 c0 ready", 32'(ready3), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #1;
            rd3 = 0;
            chk($sformatf("w3 c%0d addr", i), 32'(sram_addr3),
                (i <= 3) ? 32'd2 : 32'd3);
            chk($sformatf("w3 c%0d ready", i), 32'(ready3), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("w3 done ready", 32'(ready3), 32'd1);
        chk("w3 result", result3, 32'hF00DCAFE);

        // Reset asserted during the low phase of a store.
        @(negedge clk);
        wr = 1; addr = 1040; wdata = 32'h11112222;
        @(negedge clk);
        #1;
        chk("rst mid we_n low", 32'(sram_we_n), 32'd0);
        rst = 1'b0;
        wr = 0;
        #1;
        chk("rst mid we_n", 32'(sram_we_n), 32'd1);
        chk("rst mid oe", 32'(sram_dq_oe), 32'd0);
        chk("rst mid addr", 32'(sram_addr), 32'd0);
        chk("rst mid wdata", 32'(sram_wdata), 32'd0);
        chk("rst mid result", mem_result, 32'd0);
        chk("rst mid ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post rst ready", 32'(ready), 32'd1);
        chk("post rst we_n", 32'(sram_we_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
